// File: rtl/lpf_channel_scheduler.sv
// Shared first-order IIR low-pass datapath, time-multiplexed across
// NUM_CH channels with round-robin valid/ready arbitration.
module lpf_channel_scheduler #(
  parameter int          NUM_CH        = 4,
  parameter logic [7:0]  ALPHA_DEFAULT = 8'd40,
  localparam int         CW            = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [8*NUM_CH-1:0]   req_sample,
  output logic [NUM_CH-1:0]     req_ready,
  input  logic                  cfg_we,
  input  logic [CW-1:0]         cfg_ch,
  input  logic [7:0]            cfg_alpha,
  input  logic                  cfg_en,
  output logic                  out_valid,
  output logic [CW-1:0]         out_ch,
  output logic [7:0]            out_sample,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     ptr;
  logic [CW-1:0]     g;
  logic [CW-1:0]     cand;
  logic [CW-1:0]     gnt_idx;
  logic              gnt_any;
  logic signed [7:0] x;
  logic signed [7:0] y_prev [NUM_CH];
  logic [7:0]        alpha  [NUM_CH];
  logic [NUM_CH-1:0] en;

  logic [7:0]         a_cur;
  logic signed [7:0]  y_cur;
  logic signed [17:0] p_in;
  logic signed [17:0] p_fb;
  logic signed [17:0] sum;
  logic signed [7:0]  sat;

  // Walk from the highest offset down so the nearest request wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + CW'(k);
      if (req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_any)
      req_ready = NUM_CH'(1) << gnt_idx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nx = CALC;
      CALC:    state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

  assign a_cur = alpha[g];
  assign y_cur = y_prev[g];
  assign p_in  = $signed({10'd0, a_cur})
               * $signed({{10{x[7]}}, x});
  assign p_fb  = $signed({10'd0, 8'd128 - a_cur})
               * $signed({{10{y_cur[7]}}, y_cur});
  assign sum   = (p_in >>> 7) + (p_fb >>> 7);

  always_comb begin
    if (sum > 18'sd127)
      sat = 8'sd127;
    else if (sum < -18'sd128)
      sat = -8'sd128;
    else
      sat = sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      g          <= '0;
      x          <= '0;
      out_ch     <= '0;
      out_sample <= '0;
      en         <= '1;
      for (int k = 0; k < NUM_CH; k++) begin
        y_prev[k] <= '0;
        alpha[k]  <= ALPHA_DEFAULT;
      end
    end else begin
      state <= state_nx;
      if (cfg_we) begin
        alpha[cfg_ch] <= (cfg_alpha > 8'd128)
                       ? 8'd128 : cfg_alpha;
        en[cfg_ch]    <= cfg_en;
      end
      if (state == IDLE && gnt_any) begin
        g   <= gnt_idx;
        x   <= req_sample[{gnt_idx, 3'b000} +: 8];
        ptr <= gnt_idx + CW'(1);
      end
      if (state == CALC) begin
        out_ch <= g;
        if (en[g]) begin
          out_sample <= sat;
          y_prev[g]  <= sat;
        end else begin
          out_sample <= x;
        end
      end
    end
  end

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Scoreboard bench for lpf_channel_scheduler: directed vectors,
// expected results queued at issue and checked by an output monitor.
module tb_lpf_channel_scheduler;

  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [8*N-1:0] req_sample = '0;
  logic [N-1:0]  req_ready;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [7:0]    cfg_alpha = '0;
  logic          cfg_en = 1'b0;
  logic          out_valid;
  logic [CW-1:0] out_ch;
  logic [7:0]    out_sample;
  logic          busy;

  lpf_channel_scheduler #(
    .NUM_CH(N),
    .ALPHA_DEFAULT(8'd40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_sample(req_sample),
    .req_ready(req_ready),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_alpha(cfg_alpha),
    .cfg_en(cfg_en),
    .out_valid(out_valid),
    .out_ch(out_ch),
    .out_sample(out_sample),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   hs_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   rr_mode = 1'b0;
  int   last_hs = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hs_q.delete();
    end else begin
      if (busy)
        check("ready_while_busy", int'(req_ready), 0);
      if ((req_valid & req_ready) != '0) begin
        check("grant_onehot", $countones(req_ready), 1);
        hs_q.push_back(cyc);
        if (rr_mode) begin
          if (last_hs >= 0)
            check("rr_spacing", cyc - last_hs, 3);
          last_hs = cyc;
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_ch", int'(out_ch), e.ch);
          check("out_sample", int'($signed(out_sample)), e.val);
          if (hs_q.size() == 0)
            check("latency_no_hs", 0, 1);
          else
            check("latency", cyc - hs_q.pop_front(), 2);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cfg(int ch, int a, int e);
    @(posedge clk); #1;
    cfg_we    = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_alpha = 8'(a);
    cfg_en    = e[0];
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // mode 0: normal, 1: reset while in CALC, 2: config write while in CALC
  task automatic send(int ch, int smp, int exp, int mode);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    if (mode != 1)
      exp_q.push_back('{ch, exp});
    @(posedge clk); #1;
    req_sample[ch*8 +: 8] = 8'(smp);
    req_valid[ch] = 1'b1;
    while (!got && n < 30) begin
      @(negedge clk);
      if (req_ready[ch]) got = 1'b1;
      n++;
    end
    if (!got) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
    if (mode == 1) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("busy_after_rst", int'(busy), 0);
      check("outv_after_rst", int'(out_valid), 0);
    end else if (mode == 2) begin
      cfg_we    = 1'b1;
      cfg_ch    = CW'(ch);
      cfg_alpha = 8'd128;
      cfg_en    = 1'b1;
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic rr_run();
    int n;
    int t;
    n = 0;
    t = 0;
    exp_q.push_back('{0, 20});
    exp_q.push_back('{1, -20});
    exp_q.push_back('{2, 39});
    exp_q.push_back('{3, -40});
    exp_q.push_back('{0, 33});
    exp_q.push_back('{1, -34});
    exp_q.push_back('{2, 65});
    exp_q.push_back('{3, -68});
    last_hs = -1;
    rr_mode = 1'b1;
    @(posedge clk); #1;
    req_sample = {8'h80, 8'h7f, 8'hc0, 8'h40};
    req_valid  = '1;
    while (n < 8 && t < 60) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) n++;
      t++;
    end
    check("rr_grants", n, 8);
    @(posedge clk); #1;
    req_valid = '0;
    rr_mode = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(req_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_sample", int'(out_sample), 0);
    check("rst_busy", int'(busy), 0);

    send(0, 100, 31, 0);
    send(0, 100, 52, 0);
    send(1, -100, -32, 0);

    do_reset();
    rr_run();

    do_reset();
    cfg(2, 200, 1);
    send(2, -128, -128, 0);
    cfg(2, 128, 0);
    send(2, 77, 77, 0);
    cfg(2, 0, 1);
    send(2, 50, -128, 0);

    send(0, 100, 31, 0);
    send(0, 100, 0, 1);
    send(0, 100, 31, 0);

    send(0, 100, 52, 2);
    send(0, 10, 10, 0);

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
